// File: rtl/pht_update_scheduler_if.sv
// ---------------------------------------------------------------------------
// pht_update_scheduler_if
//   Bundles every non-clock signal of the PHT update scheduler: the
//   execute-stage update handshake, the fetch-stage read request, the
//   forwarding override, the RAM write/read ports and the sweep status.
//
//   Modports
//     slave  : the scheduler itself (consumes requests, drives RAM/status)
//     master : the surrounding BPU/execute logic (or a testbench)
//
//   Signals
//     upd_valid/upd_index/upd_data/upd_ready : update handshake
//     rd_req/rd_index/rd_grant               : fetch read request and grant
//     rd_fwd_valid/rd_fwd_data               : next-cycle override of doutb
//     ram_we/ram_waddr/ram_wdata             : RAM port A (write)
//     ram_re/ram_raddr                       : RAM port B (read)
//     init_busy                              : table sweep in progress
// ---------------------------------------------------------------------------
interface pht_update_scheduler_if #(
  parameter int INDEX_WIDTH = 8,
  parameter int DATA_WIDTH  = 56
);
  logic                   upd_valid;
  logic [INDEX_WIDTH-1:0] upd_index;
  logic [DATA_WIDTH-1:0]  upd_data;
  logic                   upd_ready;

  logic                   rd_req;
  logic [INDEX_WIDTH-1:0] rd_index;
  logic                   rd_grant;
  logic                   rd_fwd_valid;
  logic [DATA_WIDTH-1:0]  rd_fwd_data;

  logic                   ram_we;
  logic [INDEX_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0]  ram_wdata;
  logic                   ram_re;
  logic [INDEX_WIDTH-1:0] ram_raddr;

  logic                   init_busy;

  modport slave (
    input  upd_valid, upd_index, upd_data, rd_req, rd_index,
    output upd_ready, rd_grant, rd_fwd_valid, rd_fwd_data,
           ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr, init_busy
  );

  modport master (
    output upd_valid, upd_index, upd_data, rd_req, rd_index,
    input  upd_ready, rd_grant, rd_fwd_valid, rd_fwd_data,
           ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr, init_busy
  );
endinterface

// File: rtl/pht_update_scheduler.sv
// ---------------------------------------------------------------------------
// pht_update_scheduler
//   Owns both ports of the PHT simple-dual-port RAM.
//   * INIT: sweeps every index with INIT_DATA, one entry per cycle.
//   * RUN : queues execute-stage updates in an in-order FIFO and writes the
//           head whenever it does not collide with the fetch read of the
//           same index. A head blocked STARVE_LIMIT cycles in a row is
//           forced out by stealing that cycle's read slot. Reads of an index
//           with pending updates get the youngest pending value forwarded
//           one cycle later, aligned with the RAM's registered doutb.
//
//   Ports
//     clk   : clock
//     reset : synchronous active-high reset (restarts sweep, drops queue)
//     bus   : pht_update_scheduler_if.slave (update/read/RAM/status signals)
// ---------------------------------------------------------------------------
module pht_update_scheduler #(
  parameter int INDEX_WIDTH  = 8,
  parameter int DATA_WIDTH   = 56,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA = {2'b11, {(DATA_WIDTH-2){1'b0}}}
) (
  input logic                   clk,
  input logic                   reset,
  pht_update_scheduler_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT) + 1;

  localparam logic [CNT_W-1:0]       DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0]       STARVE_MAX = STV_W'(STARVE_LIMIT - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                 state_reg;
  logic [INDEX_WIDTH-1:0] sweep_reg;

  // Queue storage is kept in flops: every slot is compared against the read
  // index each cycle for forwarding.
  logic [INDEX_WIDTH-1:0] q_index_reg [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  q_data_reg  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;

  logic [STV_W-1:0]       starve_reg;
  logic                   fwd_valid_reg;
  logic [DATA_WIDTH-1:0]  fwd_data_reg;

  // -------------------------------------------------------------------------
  // Scheduling decisions
  // -------------------------------------------------------------------------
  logic                   run;
  logic                   q_empty;
  logic [INDEX_WIDTH-1:0] head_index;
  logic [DATA_WIDTH-1:0]  head_data;
  logic                   head_blocked;
  logic                   force_write;
  logic                   head_write;
  logic                   rd_grant;
  logic                   upd_ready;
  logic                   enq;

  assign run        = (state_reg == ST_RUN);
  assign q_empty    = (count_reg == '0);
  assign head_index = q_index_reg[rd_ptr_reg];
  assign head_data  = q_data_reg[rd_ptr_reg];

  // The head collides only with a read of the very same index; the read is
  // given priority until the starvation counter runs out.
  assign head_blocked = run & ~q_empty & bus.rd_req & (head_index == bus.rd_index);
  assign force_write  = head_blocked & (starve_reg == STARVE_MAX);
  assign rd_grant     = run & bus.rd_req & ~force_write;
  assign head_write   = run & ~q_empty & (~head_blocked | force_write);

  // A full queue stays not-ready even if the head drains this cycle, which
  // keeps upd_ready free of any path from the read request.
  assign upd_ready = run & (count_reg < DEPTH_C);
  assign enq       = bus.upd_valid & upd_ready;

  // -------------------------------------------------------------------------
  // Forwarding search, ordered by age (slot 0 = oldest = head)
  // -------------------------------------------------------------------------
  logic                  age_hit  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] age_data [FIFO_DEPTH];

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] slot;
      assign slot         = rd_ptr_reg + PTR_W'(gi);
      assign age_hit[gi]  = (CNT_W'(gi) < count_reg) &
                            (q_index_reg[slot] == bus.rd_index);
      assign age_data[gi] = q_data_reg[slot];
    end
  endgenerate

  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    // Later (younger) matches overwrite older ones.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (age_hit[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = age_data[i];
      end
    end
    // The update being accepted this cycle is younger than anything queued.
    if (enq && (bus.upd_index == bus.rd_index)) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.upd_data;
    end
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      sweep_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      starve_reg    <= '0;
      fwd_valid_reg <= 1'b0;
      fwd_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          sweep_reg <= sweep_reg + 1'b1;
          if (sweep_reg == LAST_INDEX) begin
            state_reg <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (enq) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (head_write) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          case ({enq, head_write})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase

          if (head_write) begin
            starve_reg <= '0;
          end else if (head_blocked) begin
            starve_reg <= starve_reg + 1'b1;
          end

          fwd_valid_reg <= rd_grant & fwd_hit;
          if (rd_grant && fwd_hit) begin
            fwd_data_reg <= fwd_data;
          end
        end

        default: state_reg <= ST_INIT;
      endcase
    end
  end

  // Queue payload needs no reset: slots are only read once count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_index_reg[wr_ptr_reg] <= bus.upd_index;
      q_data_reg[wr_ptr_reg]  <= bus.upd_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.upd_ready    = upd_ready;
  assign bus.rd_grant     = rd_grant;
  assign bus.rd_fwd_valid = fwd_valid_reg;
  assign bus.rd_fwd_data  = fwd_data_reg;

  assign bus.ram_we    = ~run | head_write;
  assign bus.ram_waddr = run ? head_index : sweep_reg;
  assign bus.ram_wdata = run ? head_data : INIT_DATA;
  assign bus.ram_re    = rd_grant;
  assign bus.ram_raddr = bus.rd_index;

  assign bus.init_busy = ~run;

endmodule

// File: tb/tb_pht_update_scheduler.sv
module tb_pht_update_scheduler;
  localparam int IW = 8;
  localparam int DW = 56;
  localparam int N  = 256;
  localparam logic [DW-1:0] INIT_D = {2'b11, 54'h0};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pht_update_scheduler_if #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  pht_update_scheduler #(
    .INDEX_WIDTH (IW),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8),
    .INIT_DATA   (INIT_D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Simple-dual-port RAM with registered read, as the BPU would attach it.
  logic [DW-1:0] ram [N];
  logic [DW-1:0] ram_dout;
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_re) ram_dout <= ram[bus.ram_raddr];
  end

  // Reference model: the architectural table as seen by software, i.e. every
  // accepted update applied immediately, plus the in-order write stream.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wr_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] model [N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Issue side: record expectations whenever a transaction is issued.
  always @(negedge clk) begin
    if (reset) begin
      wr_q.delete();
      rd_q.delete();
      for (int i = 0; i < N; i++) model[i] = INIT_D;
    end else begin
      if (bus.upd_valid && bus.upd_ready) begin
        wr_q.push_back({bus.upd_index, bus.upd_data});
        model[bus.upd_index] = bus.upd_data;
      end
      if (bus.rd_grant) rd_q.push_back(model[bus.rd_index]);
    end
  end

  // Monitor side: compare whatever the DUT presents against the queues.
  bit rd_pend  = 1'b0;
  int init_addr = 0;
  always @(negedge clk) begin : monitor
    wr_t           w;
    logic [DW-1:0] e;
    logic [DW-1:0] eff;
    if (reset) begin
      rd_pend   = 1'b0;
      init_addr = 0;
    end else begin
      if (rd_pend) begin
        eff = bus.rd_fwd_valid ? bus.rd_fwd_data : ram_dout;
        if (rd_q.size() == 0) begin
          chk("rd_q_underflow", 64'd0, 64'd1);
        end else begin
          e = rd_q.pop_front();
          $display("read  idx=%h data=%h fwd=%0d", bus.ram_raddr, eff, bus.rd_fwd_valid);
          chk("rd_data", eff, e);
        end
      end
      rd_pend = bus.rd_grant;

      if (bus.init_busy) begin
        chk("init_quiet", {bus.rd_grant, bus.upd_ready, bus.ram_re}, 64'd0);
        chk("init_we", bus.ram_we, 64'd1);
        chk("init_addr", bus.ram_waddr, init_addr[7:0]);
        chk("init_data", bus.ram_wdata, INIT_D);
        init_addr++;
      end else if (bus.ram_we) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 64'd0, 64'd1);
        end else begin
          w = wr_q.pop_front();
          $display("write idx=%h data=%h", bus.ram_waddr, bus.ram_wdata);
          chk("wr_addr", bus.ram_waddr, w.idx);
          chk("wr_data", bus.ram_wdata, w.data);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (all return at posedge+1)
  // -------------------------------------------------------------------------
  task automatic send_upd(input logic [IW-1:0] idx, input logic [DW-1:0] data);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    bus.upd_valid = 1'b1;
    bus.upd_index = idx;
    bus.upd_data  = data;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = bus.upd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.upd_valid = 1'b0;
    chk("upd_accept", acc, 64'd1);
  endtask

  // Called at the first negedge of the sweep, already counted as n0.
  task automatic wait_init(input int n0);
    int n;
    n = n0;
    while (n < 300) begin
      @(negedge clk);
      if (!bus.init_busy) break;
      n++;
    end
    chk("init_cycles", n, 64'd256);
    chk("ready_after_init", bus.upd_ready, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.upd_valid = 1'b0;
    bus.rd_req    = 1'b0;
    while (wr_q.size() != 0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", wr_q.size(), 64'd0);
  endtask

  task automatic chk_mem_model(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== model[i]) bad++;
    chk(name, bad, 64'd0);
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.upd_valid = 1'($urandom_range(0, 1));
      bus.upd_index = 8'($urandom_range(0, 7));
      bus.upd_data  = rand_data();
      bus.rd_req    = ($urandom_range(0, 3) != 0);
      bus.rd_index  = 8'($urandom_range(0, 7));
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    bus.upd_valid = 1'b0;
    bus.upd_index = '0;
    bus.upd_data  = '0;
    bus.rd_req    = 1'b0;
    bus.rd_index  = '0;

    // Reset and initial sweep
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_init_busy", bus.init_busy, 64'd1);
    chk("rst_fwd_valid", bus.rd_fwd_valid, 64'd0);
    chk("rst_waddr", bus.ram_waddr, 64'd0);
    wait_init(1);
    chk_mem_model("mem_after_init");
    @(posedge clk);
    #1;

    // Single update with no reads: written the following cycle
    d1 = rand_data();
    bus.upd_valid = 1'b1;
    bus.upd_index = 8'h12;
    bus.upd_data  = d1;
    @(negedge clk);
    chk("upd_not_same_cycle", bus.ram_we, 64'd0);
    @(posedge clk);
    #1 bus.upd_valid = 1'b0;
    @(negedge clk);
    chk("upd_we", bus.ram_we, 64'd1);
    chk("upd_waddr", bus.ram_waddr, 64'h12);
    chk("upd_wdata", bus.ram_wdata, d1);
    @(posedge clk);
    #1;

    // Starvation: continuous reads of the head index
    d1 = rand_data();
    bus.rd_req    = 1'b1;
    bus.rd_index  = 8'h12;
    bus.upd_valid = 1'b1;
    bus.upd_index = 8'h12;
    bus.upd_data  = d1;
    @(posedge clk);
    #1 bus.upd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("starve_fwd_valid", bus.rd_fwd_valid, 64'd1);
      chk("starve_fwd_data", bus.rd_fwd_data, d1);
      if (k < 8) begin
        chk("starve_grant", bus.rd_grant, 64'd1);
        chk("starve_we", bus.ram_we, 64'd0);
      end else begin
        chk("force_grant", bus.rd_grant, 64'd0);
        chk("force_we", bus.ram_we, 64'd1);
        chk("force_waddr", bus.ram_waddr, 64'h12);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("post_force_grant", bus.rd_grant, 64'd1);
    @(posedge clk);
    #1 bus.rd_req = 1'b0;
    @(negedge clk);
    chk("post_force_fwd_valid", bus.rd_fwd_valid, 64'd0);
    chk("post_force_ram", ram_dout, d1);
    @(posedge clk);
    #1;

    // Queue fill while the head is blocked
    bus.rd_req   = 1'b1;
    bus.rd_index = 8'h33;
    send_upd(8'h33, rand_data());
    send_upd(8'h01, rand_data());
    send_upd(8'h02, rand_data());
    send_upd(8'h03, rand_data());
    bus.upd_valid = 1'b1;
    @(negedge clk);
    chk("full_not_ready", bus.upd_ready, 64'd0);
    @(posedge clk);
    #1;
    send_upd(8'h04, rand_data());
    drain();
    chk_mem_model("mem_after_full");

    // Duplicate index: youngest value forwarded and left in RAM
    d1 = rand_data();
    d2 = rand_data();
    bus.rd_req   = 1'b1;
    bus.rd_index = 8'h40;
    send_upd(8'h40, d1);
    send_upd(8'h40, d2);
    @(negedge clk);
    chk("dup_fwd_valid", bus.rd_fwd_valid, 64'd1);
    chk("dup_fwd_data", bus.rd_fwd_data, d2);
    @(posedge clk);
    #1;
    drain();
    chk("dup_ram", ram[8'h40], d2);

    // Randomized traffic on a small index set
    run_random(1500);
    chk_mem_model("mem_after_random");

    // Reset with entries queued and reads in flight
    bus.rd_req   = 1'b1;
    bus.rd_index = 8'h55;
    send_upd(8'h55, rand_data());
    send_upd(8'h56, rand_data());
    send_upd(8'h57, rand_data());
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst2_init_busy", bus.init_busy, 64'd1);
    chk("rst2_waddr", bus.ram_waddr, 64'd0);
    chk("rst2_fwd_valid", bus.rd_fwd_valid, 64'd0);
    chk("rst2_upd_ready", bus.upd_ready, 64'd0);
    chk("rst2_grant", bus.rd_grant, 64'd0);
    wait_init(1);
    bus.rd_req = 1'b0;
    chk_mem_model("mem_after_reinit");
    @(posedge clk);
    #1;

    run_random(300);
    chk_mem_model("mem_final");
    chk("rd_q_empty", rd_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish before 1000000");
    $fatal(1);
  end

endmodule
